// File: rtl/demux4_router.sv
// Four-lane word distributor: one valid/ready input steered into four single-entry lane buffers,
// target chosen by an explicit select or a round-robin pointer.
module demux4_router #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [1:0]       in_sel,
    input  logic             rr_mode,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] dispatch_count
);

    logic [1:0]       w_target;
    logic             w_ready;
    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_consume;
    logic [3:0]       w_valid_d;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_rr_ptr;
    logic [CNT_W-1:0] r_count;

    // Ready never looks at in_valid, so a producer waiting on ready cannot form a loop.
    always_comb begin
        w_target  = rr_mode ? r_rr_ptr : in_sel;
        w_ready   = ~r_valid[w_target] | out_ack[w_target];
        w_accept  = in_valid & w_ready;
        w_load    = 4'b0000;
        if (w_accept) begin
            w_load[w_target] = 1'b1;
        end
        w_consume = r_valid & out_ack;
        // A load into a lane being consumed on the same edge keeps it valid.
        w_valid_d = w_load | (r_valid & ~w_consume);
        w_cnt_sat = &r_count;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 4'b0000;
        end else begin
            r_valid <= w_valid_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept && rr_mode) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept && !w_cnt_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        in_ready       = w_ready;
        out_data0      = r_data[0];
        out_data1      = r_data[1];
        out_data2      = r_data[2];
        out_data3      = r_data[3];
        out_valid      = r_valid;
        rr_ptr         = r_rr_ptr;
        dispatch_count = r_count;
    end

endmodule

// File: tb/tb_demux4_router.sv
// Randomized and directed bench for demux4_router against a lane-array reference model.
module tb_demux4_router;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic        rr_mode;
    logic [3:0]  out_ack;

    logic        in_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [1:0]  rr_ptr;
    logic [3:0]  dispatch_count;

    logic        in_ready_w;
    logic [31:0] w_d0, w_d1, w_d2, w_d3;
    logic [3:0]  out_valid_w;
    logic [1:0]  rr_ptr_w;
    logic [15:0] dispatch_count_w;

    demux4_router #(.WIDTH(32), .CNT_W(4)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sel         (in_sel),
        .rr_mode        (rr_mode),
        .in_ready       (in_ready),
        .out_data0      (out_data0),
        .out_data1      (out_data1),
        .out_data2      (out_data2),
        .out_data3      (out_data3),
        .out_valid      (out_valid),
        .out_ack        (out_ack),
        .rr_ptr         (rr_ptr),
        .dispatch_count (dispatch_count)
    );

    // Default-width twin on the same stimulus, to see the counter before it saturates.
    demux4_router u_dut_wide (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sel         (in_sel),
        .rr_mode        (rr_mode),
        .in_ready       (in_ready_w),
        .out_data0      (w_d0),
        .out_data1      (w_d1),
        .out_data2      (w_d2),
        .out_data3      (w_d3),
        .out_valid      (out_valid_w),
        .out_ack        (out_ack),
        .rr_ptr         (rr_ptr_w),
        .dispatch_count (dispatch_count_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_err;

    // Reference model: four lanes, a pointer and a saturating count of accepted words.
    logic [31:0] m_data [4];
    logic        m_valid [4];
    int          m_ptr;
    int          m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_data[i]  = 32'd0;
            m_valid[i] = 1'b0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic check_state();
        check_val("out_valid", 64'(out_valid), 64'(model_valid_vec()));
        check_val("out_data0", 64'(out_data0), 64'(m_data[0]));
        check_val("out_data1", 64'(out_data1), 64'(m_data[1]));
        check_val("out_data2", 64'(out_data2), 64'(m_data[2]));
        check_val("out_data3", 64'(out_data3), 64'(m_data[3]));
        check_val("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
        check_val("count4", 64'(dispatch_count), 64'((m_cnt > 15) ? 15 : m_cnt));
        check_val("count16", 64'(dispatch_count_w), 64'(m_cnt));
    endtask

    logic last_accept;

    // One cycle: drive at the negedge, check ready, clock, update the model, check state.
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] s, input logic m,
                        input logic [3:0] a);
        int   tgt;
        logic rdy;
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        rr_mode  = m;
        out_ack  = a;
        #1;
        tgt = m ? m_ptr : int'(s);
        rdy = !m_valid[tgt] || a[tgt];
        check_val("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            if (a[i]) m_valid[i] = 1'b0;
        end
        last_accept = v && rdy;
        if (v && rdy) begin
            m_data[tgt]  = d;
            m_valid[tgt] = 1'b1;
            m_cnt        = m_cnt + 1;
            if (m) m_ptr = (m_ptr + 1) % 4;
        end
        #1;
        check_state();
        @(negedge clock);
    endtask

    initial begin
        logic        hv;
        logic [31:0] hd;
        logic [1:0]  hs;
        logic        hm;
        n_cmp       = 0;
        n_err       = 0;
        last_accept = 1'b1;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        in_sel      = 2'd0;
        rr_mode     = 1'b0;
        out_ack     = 4'b0000;
        reset       = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check_state();
        check_val("reset_ready", 64'(in_ready), 64'd1);

        // Round-robin with all consumers acking.
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + 32'(i), 2'd0, 1'b1, 4'b1111);
        check_val("rr_ptr_end", 64'(rr_ptr), 64'd2);
        check_val("rr_count", 64'(dispatch_count_w), 64'd6);
        check_val("rr_lane0", 64'(out_data0), 64'hA4);
        check_val("rr_lane1", 64'(out_data1), 64'hA5);

        // Backpressure on lane 2, then in-place replacement on ack.
        step(1'b0, 32'h0, 2'd0, 1'b0, 4'b1111);
        step(1'b1, 32'h11, 2'd2, 1'b0, 4'b0000);
        check_val("bp_first", 64'(out_data2), 64'h11);
        step(1'b1, 32'h22, 2'd2, 1'b0, 4'b0000);
        check_val("bp_held", 64'(out_data2), 64'h11);
        step(1'b1, 32'h22, 2'd2, 1'b0, 4'b0100);
        check_val("bp_replace_v", 64'(out_valid[2]), 64'd1);
        check_val("bp_replace_d", 64'(out_data2), 64'h22);

        // Spurious ack on empty lane 0, then four rr accepts across the wrap.
        step(1'b0, 32'h0, 2'd0, 1'b0, 4'b1111);
        step(1'b0, 32'h0, 2'd0, 1'b1, 4'b0001);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 2'd0, 1'b1, 4'b0000);
        check_val("wrap_valid", 64'(out_valid), 64'hF);
        check_val("wrap_ptr", 64'(rr_ptr), 64'd2);

        // Mode toggle keeps the pointer.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 2'd0, 1'b1, 4'b1111);
        check_val("tog_ptr1", 64'(rr_ptr), 64'd1);
        step(1'b1, 32'hD0, 2'd3, 1'b0, 4'b1111);
        step(1'b1, 32'hD1, 2'd3, 1'b0, 4'b1111);
        check_val("tog_lane3", 64'(out_data3), 64'hD1);
        check_val("tog_ptr_hold", 64'(rr_ptr), 64'd1);
        step(1'b1, 32'hD2, 2'd3, 1'b1, 4'b0000);
        check_val("tog_back", 64'(out_data1), 64'hD2);

        // Reset between edges with all lanes full.
        step(1'b0, 32'h0, 2'd0, 1'b1, 4'b1111);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + 32'(i), 2'd0, 1'b1, 4'b0000);
        in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_state();
        check_val("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 32'hF0, 2'd3, 1'b1, 4'b0000);
        check_val("rst_first", 64'(out_valid), 64'h1);

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h100 + 32'(i), 2'd0, 1'b1, 4'b1111);
            if (i == 14) check_val("sat_15", 64'(dispatch_count), 64'hF);
        end
        check_val("sat_hold", 64'(dispatch_count), 64'hF);
        check_val("sat_wide", 64'(dispatch_count_w), 64'd21);

        // Random traffic; an offered word that stalled is held stable.
        hv = 1'b0; hd = 32'd0; hs = 2'd0; hm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hv || last_accept) begin
                hv = ($urandom_range(0, 3) != 0);
                hd = $urandom;
                hs = 2'($urandom_range(0, 3));
                hm = 1'($urandom_range(0, 1));
            end
            step(hv, hd, hs, hm, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/demux4_router.md
# demux4_router

Four-lane word distributor: accepts one WIDTH-bit word per cycle over a valid/ready handshake and steers it into one of four single-entry output lane buffers. Each lane presents its word to its consumer until that consumer acknowledges it. The target lane comes from an explicit 2-bit select or from an internal round-robin pointer. It sits on the fan-out side of the datapath, opposite the 4:1 select muxes that merge lanes back together.

## Interface
Parameters:
- WIDTH, 32, data word width.
- CNT_W, 16, width of the dispatch counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0, clears all state immediately.
- in_data  in  WIDTH  word offered by the producer.
- in_valid  in  1  producer has a word.
- in_sel  in  2  target lane when rr_mode=0.
- rr_mode  in  1  1 = target is the round-robin pointer, 0 = target is in_sel.
- in_ready  out  1  combinational; the target lane can accept this cycle.
- out_data0..out_data3  out  WIDTH each  lane holding registers.
- out_valid  out  4  bit i = lane i holds an unconsumed word.
- out_ack  in  4  bit i = consumer i takes lane i this cycle.
- rr_ptr  out  2  current round-robin pointer.
- dispatch_count  out  CNT_W  number of accepted words, saturating.

## Operation
- target = rr_mode ? rr_ptr : in_sel.
- in_ready = ~out_valid[target] | out_ack[target]. In-place replacement is allowed when the lane is acked in the same cycle.
- Accept occurs when in_valid & in_ready. On accept:
  - out_data[target] <= in_data.
  - out_valid[target] <= 1.
  - dispatch_count increments, holding at all-ones.
  - If rr_mode=1, rr_ptr <= rr_ptr+1 (wraps 3 -> 0).
- If rr_mode=0, rr_ptr holds. Toggling rr_mode never resets rr_ptr.
- Lane consume: out_valid[i] & out_ack[i] clears out_valid[i] unless the same lane is loaded in that cycle; load wins, so valid stays 1 with the new data.
- out_ack[i] while out_valid[i]=0 is ignored.
- out_data[i] holds its last value after consume; it is not cleared.
- in_data is don't-care when in_valid=0. Nothing is accepted and no state changes on the input side.
- Only the target lane is ever written in a cycle. Non-target lanes change only through their own ack.
- Stall: if the target lane is full and not acked, in_ready=0. The producer must hold in_valid/in_data/in_sel stable until accepted. In rr mode, words are not redirected to other free lanes (strict ordering).

## Timing
- Reset (reset=0, asynchronous): out_valid=4'b0000, out_data0..3=0, rr_ptr=0, dispatch_count=0. in_ready therefore reads 1 immediately after reset.
- Reset mid-operation discards all buffered words without handshake.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle sustained when the target lane is empty or acked each cycle.
- in_ready depends combinationally on rr_mode, in_sel, rr_ptr, out_valid and out_ack. It has no dependency on in_valid, so there is no combinational loop with a producer that waits on ready.
- Simultaneous accept to lane j and acks on other lanes: all take effect on the same edge.
- dispatch_count saturation: at all-ones, further accepts are still performed but the count does not wrap.

## Test plan
- Round-robin: reset, rr_mode=1, out_ack=4'b1111, in_valid held for words 0xA0..0xA5. Required: lanes 0,1,2,3,0,1 loaded in order; rr_ptr=2 at end; dispatch_count=6; in_ready=1 throughout.
- Backpressure: rr_mode=0, in_sel=2, out_ack=0. Send 0x11, then 0x22. Required: 0x11 latched in lane 2; in_ready=0 while 0x22 is offered. Pulse out_ack[2]; 0x22 is accepted that cycle and out_valid[2] stays 1 with out_data2=0x22.
- Ignored ack and wrap: rr_mode=1, out_ack=4'b0001 with lane 0 empty, then 4 accepts. Required: spurious ack has no effect; rr_ptr wraps 3->0; the lane-0 word is accepted and out_valid[0]=1.
- Mode toggle: rr_mode=1 with rr_ptr=1, switch to rr_mode=0 with in_sel=3, accept 2 words, switch back. Required: words go to lane 3; rr_ptr stays 1; the next rr word goes to lane 1.
- Reset mid-stream: all lanes full and in_valid=1; drive reset=0 between clock edges. Required: out_valid=0, rr_ptr=0, dispatch_count=0 with no clock edge; first accept after release targets lane 0.
- Saturation: CNT_W=4, 20 accepts with acks on. Required: dispatch_count=4'hF after the 15th accept and it stays there; all 20 words are delivered.
